// File: rtl/vz_pkg.sv
// vz_pkg: shared types and constants for the .VZ snapshot loader
package vz_pkg;
  typedef enum logic [2:0] {IDLE, HEADER, BODY, WRITE, PATCH_LO, PATCH_HI, DONE, ERROR} state_t;
  localparam logic [31:0] VZ_MAGIC = 32'h565A4630;
  localparam int HDR_TYPE = 21;
  localparam int HDR_ADDR_LO = 22;
  localparam int HDR_ADDR_HI = 23;
  localparam logic [15:0] BASIC_END_PTR = 16'h78F9;
  localparam logic [7:0] TYPE_BASIC = 8'hF0;
  localparam logic [7:0] TYPE_MC = 8'hF1;
  function automatic logic [7:0] magic_byte(input logic [1:0] i);
    return 8'(VZ_MAGIC >> {~i, 3'b000});
  endfunction
endpackage

// File: rtl/vz_loader.sv
// vz_loader: parses a streamed .VZ snapshot and writes its body into RAM.
// Optional BASIC end-pointer patch and run request under VZ_AUTORUN_EN.
module vz_loader
  import vz_pkg::*;
#(
  parameter logic [7:0] VZ_INDEX = 8'h01,
  parameter int HDR_LEN = 24
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_wr,
  input  logic        mem_ack,
  output logic [7:0]  file_type,
  output logic [15:0] start_addr,
  output logic        load_done,
  output logic        load_error,
  output logic        run_req
);
  logic act_q, active, rise, hdr_bad, hdr_wr;
  logic [15:0] body_addr;
  state_t state, nxt, fin;
  assign active = ioctl_download && ioctl_index == VZ_INDEX;
  assign rise = active && !act_q;
  assign hdr_wr = state == HEADER && active && ioctl_wr;
  assign hdr_bad = ioctl_wr && ioctl_addr < 25'd4 && ioctl_dout != magic_byte(ioctl_addr[1:0]);
  assign body_addr = start_addr + ioctl_addr[15:0] - 16'(HDR_LEN);
`ifdef VZ_AUTORUN_EN
  logic [15:0] end_ptr;
  assign fin = file_type == TYPE_BASIC ? PATCH_LO : DONE;
`else
  assign fin = DONE;
  assign run_req = 1'b0;
`endif
  always_ff @(posedge clk_50 or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      HEADER: nxt = (!active || hdr_bad) ? ERROR : (ioctl_wr && ioctl_addr == 25'(HDR_ADDR_HI)) ? BODY : HEADER;
      BODY: nxt = !active ? fin : (ioctl_wr && !ioctl_wait) ? WRITE : BODY;
      WRITE: nxt = !mem_ack ? WRITE : active ? BODY : fin;
`ifdef VZ_AUTORUN_EN
      PATCH_LO: nxt = mem_ack ? PATCH_HI : PATCH_LO;
      PATCH_HI: nxt = mem_ack ? DONE : PATCH_HI;
`endif
      default: nxt = state;
    endcase
    if (rise) nxt = HEADER;
  end
  always_ff @(posedge clk_50 or posedge reset)
    if (reset) begin
      act_q <= 1'b0;
      ioctl_wait <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      mem_wr <= 1'b0;
      file_type <= '0;
      start_addr <= '0;
      load_done <= 1'b0;
      load_error <= 1'b0;
`ifdef VZ_AUTORUN_EN
      end_ptr <= '0;
      run_req <= 1'b0;
`endif
    end else begin
      act_q <= active;
`ifdef VZ_AUTORUN_EN
      run_req <= 1'b0;
`endif
      if (rise) begin
        load_done <= 1'b0;
        load_error <= 1'b0;
        file_type <= '0;
        start_addr <= '0;
        mem_wr <= 1'b0;
        ioctl_wait <= 1'b0;
      end else begin
        if (hdr_wr && ioctl_addr == 25'(HDR_TYPE)) file_type <= ioctl_dout;
        if (hdr_wr && ioctl_addr == 25'(HDR_ADDR_LO)) start_addr[7:0] <= ioctl_dout;
        if (hdr_wr && ioctl_addr == 25'(HDR_ADDR_HI)) start_addr[15:8] <= ioctl_dout;
`ifdef VZ_AUTORUN_EN
        if (hdr_wr && ioctl_addr == 25'(HDR_ADDR_HI)) end_ptr <= {ioctl_dout, start_addr[7:0]};
`endif
        if (state == BODY && nxt == WRITE) begin
          mem_addr <= body_addr;
          mem_data <= ioctl_dout;
          mem_wr <= 1'b1;
          ioctl_wait <= 1'b1;
`ifdef VZ_AUTORUN_EN
          end_ptr <= body_addr + 16'd1;
`endif
        end else if (state == BODY) ioctl_wait <= 1'b0;
        // a strobe during the throttle window is lost; the pending write still completes
        if ((state == BODY || state == WRITE) && active && ioctl_wr && ioctl_wait) load_error <= 1'b1;
        if (state == WRITE && mem_ack) mem_wr <= 1'b0;
`ifdef VZ_AUTORUN_EN
        if (nxt == PATCH_LO && state != PATCH_LO) begin
          mem_addr <= BASIC_END_PTR;
          mem_data <= end_ptr[7:0];
          mem_wr <= 1'b1;
          ioctl_wait <= 1'b0;
        end
        if (nxt == PATCH_HI && state == PATCH_LO) begin
          mem_addr <= BASIC_END_PTR + 16'd1;
          mem_data <= end_ptr[15:8];
          mem_wr <= 1'b1;
        end
        if (state == PATCH_HI && mem_ack) mem_wr <= 1'b0;
        if (nxt == DONE && state != DONE) run_req <= !load_error;
`endif
        if (nxt == DONE && state != DONE) begin
          load_done <= !load_error;
          ioctl_wait <= 1'b0;
        end
        if (nxt == ERROR && state != ERROR) load_error <= 1'b1;
      end
    end
endmodule

// File: tb/tb_vz_loader.sv
// tb_vz_loader: table-driven .VZ loads with a write scoreboard and corner sequences
module tb_vz_loader;
  import vz_pkg::*;
  localparam int ACK_DLY = 2;
  logic clk_50 = 1'b0, reset = 1'b1, ioctl_download = 1'b0, ioctl_wr = 1'b0, mem_ack = 1'b0;
  logic [7:0] ioctl_index = '0, ioctl_dout = '0;
  logic [24:0] ioctl_addr = '0;
  logic ioctl_wait, mem_wr, load_done, load_error, run_req;
  logic [15:0] mem_addr, start_addr;
  logic [7:0] mem_data, file_type;

  vz_loader dut (
    .clk_50(clk_50), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr(mem_wr), .mem_ack(mem_ack),
    .file_type(file_type), .start_addr(start_addr), .load_done(load_done),
    .load_error(load_error), .run_req(run_req)
  );

  always #5 clk_50 = ~clk_50;

  typedef struct { logic [15:0] a; logic [7:0] d; } wr_t;
  typedef struct { logic [31:0] magic; logic [7:0] ftype; logic [15:0] addr; int blen; logic [7:0] dbase; int cut; } vec_t;
  wr_t q[$];
  vec_t vt[10];
  int vectors = 0, miscompares = 0, runs = 0, ack_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RAM model: acks each request ACK_DLY cycles after it is seen and scores the write
  always @(negedge clk_50) begin
    wr_t e;
    if (run_req) runs++;
    if (!mem_wr || reset) begin
      ack_cnt = 0;
      mem_ack = 1'b0;
    end else if (mem_ack) mem_ack = 1'b0;
    else if (++ack_cnt == ACK_DLY) begin
      ack_cnt = 0;
      mem_ack = 1'b1;
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_wr: got %0h=%0h expected no write", mem_addr, mem_data);
      end else begin
        e = q.pop_front();
        chk("wr_addr", mem_addr, e.a);
        chk("wr_data", mem_data, e.d);
      end
    end
  end

  function automatic logic [7:0] vbyte(input vec_t v, input int i);
    return i < 4 ? 8'(v.magic >> (8 * (3 - i))) : i < 21 ? 8'(32'h20 + i) : i == 21 ? v.ftype :
           i == 22 ? v.addr[7:0] : i == 23 ? v.addr[15:8] : 8'(v.dbase + 17 * (i - 24));
  endfunction

  task automatic strobe(input int a, input logic [7:0] d);
    ioctl_addr = 25'(a);
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    @(negedge clk_50);
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_free(output int n);
    n = 0;
    while (ioctl_wait && n < 50) begin
      @(negedge clk_50);
      n++;
    end
  endtask

  task automatic start_dl(input logic [7:0] idx);
    @(negedge clk_50);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    @(negedge clk_50);
  endtask

  task automatic run_vec(input vec_t v);
    int n, nw;
    logic ok_magic, ok;
    logic [7:0] b;
    logic [15:0] e16;
    ok_magic = v.magic == VZ_MAGIC;
    n = v.cut < 0 ? 24 + v.blen : v.cut;
    ok = ok_magic && n >= 24;
    runs = 0;
    start_dl(8'h01);
    chk("rise_clear", {load_done, load_error}, 2'b00);
    for (int i = 0; i < n; i++) begin
      b = vbyte(v, i);
      if (i >= 24 && ok_magic) q.push_back('{a: 16'(v.addr + 16'(i - 24)), d: b});
      strobe(i, b);
      if (i == 3) chk("magic_err", load_error, !ok_magic);
      if (i == 23 && ok_magic) chk("hdr_nowait", ioctl_wait, 0);
      if (i >= 24 && ok_magic) begin
        wait_free(nw);
        chk("wait_cycles", nw, 3);
      end
    end
`ifdef VZ_AUTORUN_EN
    if (ok && v.ftype == TYPE_BASIC) begin
      e16 = v.addr + 16'(n - 24);
      q.push_back('{a: BASIC_END_PTR, d: e16[7:0]});
      q.push_back('{a: BASIC_END_PTR + 16'd1, d: e16[15:8]});
    end
`endif
    ioctl_download = 1'b0;
    repeat (16) @(negedge clk_50);
    chk("load_done", load_done, ok);
    chk("load_error", load_error, !ok);
    if (ok) begin
      chk("file_type", file_type, v.ftype);
      chk("start_addr", start_addr, v.addr);
    end
    chk("pending_wr", q.size(), 0);
    q.delete();
`ifdef VZ_AUTORUN_EN
    chk("run_req", runs, (ok ? 1 : 0));
`else
    chk("run_req", runs, 0);
`endif
  endtask

  task automatic send_hdr(input vec_t v);
    for (int i = 0; i < 24; i++) strobe(i, vbyte(v, i));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nw;
    vt[0] = '{32'h565A4630, 8'hF1, 16'h8000, 3, 8'hAA, -1};
    vt[1] = '{32'h565A4631, 8'hF1, 16'h8000, 3, 8'hAA, -1};
    vt[2] = '{32'h565A4630, 8'hF1, 16'h9000, 2, 8'h10, 10};
    vt[3] = '{32'h565A4630, 8'hF0, 16'h9000, 2, 8'h10, -1};
    vt[4] = '{32'h565A4630, 8'hF1, 16'hFFFE, 4, 8'h01, -1};
    vt[5] = '{32'h565A4630, 8'hF1, 16'h4000, 0, 8'h00, -1};
    vt[6] = '{32'h565A4630, 8'hF0, 16'h7AE9, 5, 8'h55, -1};
    vt[7] = '{32'h465A4630, 8'hF1, 16'h1000, 1, 8'h00, -1};
    vt[8] = '{32'h565A4630, 8'hF1, 16'h2000, 4, 8'h40, 26};
    vt[9] = '{32'h565A4630, 8'hF0, 16'hC000, 0, 8'h00, -1};
    repeat (3) @(negedge clk_50);
    chk("rst_outputs", {ioctl_wait, mem_wr, load_done, load_error, run_req}, 0);
    chk("rst_data", {mem_addr, mem_data}, 0);
    chk("rst_hdr", {file_type, start_addr}, 0);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) run_vec(vt[k]);

    // other download slots must leave every output alone
    start_dl(8'h02);
    for (int i = 0; i < 28; i++) strobe(i, vbyte(vt[0], i));
    ioctl_download = 1'b0;
    repeat (6) @(negedge clk_50);
    chk("idx_done", load_done, 1);
    chk("idx_err", load_error, 0);
    chk("idx_type", file_type, vt[9].ftype);
    chk("idx_addr", start_addr, vt[9].addr);

    // strobe during ioctl_wait is dropped and flagged
    start_dl(8'h01);
    send_hdr('{32'h565A4630, 8'hF1, 16'h5000, 2, 8'h11, -1});
    q.push_back('{a: 16'h5000, d: 8'h11});
    strobe(24, 8'h11);
    chk("drop_wait_hi", ioctl_wait, 1);
    strobe(25, 8'h22);
    wait_free(nw);
    ioctl_download = 1'b0;
    repeat (16) @(negedge clk_50);
    chk("drop_err", load_error, 1);
    chk("drop_pending", q.size(), 0);
    q.delete();

    // asynchronous reset while a write is outstanding
    start_dl(8'h01);
    send_hdr('{32'h565A4630, 8'hF1, 16'h6000, 1, 8'h33, -1});
    q.push_back('{a: 16'h6000, d: 8'h33});
    strobe(24, 8'h33);
    chk("pre_rst_memwr", mem_wr, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_memwr", mem_wr, 0);
    chk("rst_wait", ioctl_wait, 0);
    chk("rst_state", dut.state, IDLE);
    chk("rst_flags", {load_done, load_error, file_type, start_addr}, 0);
    q.delete();
    @(negedge clk_50);
    ioctl_download = 1'b0;
    @(negedge clk_50);
    reset = 1'b0;
    run_vec(vt[0]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
